// File: rtl/morse_msg_scheduler.sv
// morse_msg_scheduler
//   Message-level controller that sits in front of a single-character Morse
//   encoder. The host pushes character codes into a small FIFO. The scheduler
//   hands them to the encoder one at a time over a start/done handshake. After
//   each encoded character it inserts the inter-character gap. A word-space
//   code adds the remaining part of the inter-word gap.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   host presents in_char
//   in_ready   FIFO not full; a push happens on in_valid && in_ready
//   in_char    0..25 = A..Z, 26 = word space, 27..31 = invalid
//   enc_start  one-cycle pulse: encoder should send enc_sel
//   enc_sel    character code for the encoder, stable between starts
//   enc_done   encoder pulse: current character finished
//   busy       FSM not idle or FIFO not empty
//   level      FIFO occupancy
//   err        one-cycle pulse when an invalid code is popped
//
// Parameter constraints: DEPTH is a power of two and >= 2;
// WORD_GAP_UNITS > CHAR_GAP_UNITS; UNIT_CYCLES >= 1; CHAR_GAP_UNITS >= 1.
module morse_msg_scheduler #(
    parameter int DEPTH          = 8,
    parameter int UNIT_CYCLES    = 100,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7,
    parameter int LVL_W          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_char,
    output logic             enc_start,
    output logic [4:0]       enc_sel,
    input  logic             enc_done,
    output logic             busy,
    output logic [LVL_W-1:0] level,
    output logic             err
);

    localparam int PTR_W = $clog2(DEPTH);

    // Gap lengths in clock cycles. They are fixed at elaboration, so no
    // multiplier is built.
    localparam int CHAR_GAP_CYC = CHAR_GAP_UNITS * UNIT_CYCLES;
    localparam int WORD_EXT_CYC = (WORD_GAP_UNITS - CHAR_GAP_UNITS) * UNIT_CYCLES;
    // Sized for the full word gap, so either load value always fits.
    localparam int GAP_W        = $clog2(WORD_GAP_UNITS * UNIT_CYCLES + 1);

    localparam logic [GAP_W-1:0] CHAR_GAP_LD = GAP_W'(CHAR_GAP_CYC);
    localparam logic [GAP_W-1:0] WORD_EXT_LD = GAP_W'(WORD_EXT_CYC);
    localparam logic [GAP_W-1:0] GAP_ONE     = GAP_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE     = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    localparam logic [4:0] CODE_SPACE = 5'd26;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [4:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       head;
    logic             push;
    logic             pop;
    logic [1:0]       state;
    logic [GAP_W-1:0] gap;

    // in_ready depends only on level. A pop in the same cycle does not
    // open a slot for a push into a full FIFO.
    assign in_ready = (level != LVL_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && (level != '0);
    assign head     = mem[rd_ptr];
    assign busy     = (state != S_IDLE) || (level != '0);

    // Storage is not reset. Entries are only read when level says they are
    // valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_char;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    //   IDLE  -> pop the head; a letter starts the encoder, a space opens
    //            the extra word gap, and an invalid code flags err and stays
    //            here. Staying here lets back-to-back pops happen.
    //   START -> the cycle in which enc_start is high.
    //   WAIT  -> wait for enc_done, then open the character gap.
    //   GAP   -> count down. It lasts exactly the loaded number of cycles.
    // enc_done is only looked at in WAIT. A reset drops any character in
    // flight, so a late done from the encoder has no effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            enc_start <= 1'b0;
            enc_sel   <= '0;
            err       <= 1'b0;
            gap       <= '0;
        end else begin
            enc_start <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        if (head < CODE_SPACE) begin
                            enc_sel   <= head;
                            // Registered, so the pulse lines up with START.
                            enc_start <= 1'b1;
                            state     <= S_START;
                        end else if (head == CODE_SPACE) begin
                            // The character gap has already run, so only the
                            // remainder of the word gap is added here.
                            gap   <= WORD_EXT_LD;
                            state <= S_GAP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (enc_done) begin
                        gap   <= CHAR_GAP_LD;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    gap <= gap - GAP_ONE;
                    // Leaving at 1 makes the GAP stay equal to the load value.
                    // The <= also guards against a zero-length load.
                    if (gap <= GAP_ONE) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_msg_scheduler.sv
module tb_morse_msg_scheduler;

    localparam int DEPTH = 4;
    localparam int UNIT  = 4;
    localparam int CGAP  = 3;
    localparam int WGAP  = 7;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int N     = CGAP * UNIT;            // 12
    localparam int M     = (WGAP - CGAP) * UNIT;   // 16

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_char;
    logic             enc_start;
    logic [4:0]       enc_sel;
    logic             enc_done;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             err;

    morse_msg_scheduler #(
        .DEPTH(DEPTH), .UNIT_CYCLES(UNIT),
        .CHAR_GAP_UNITS(CGAP), .WORD_GAP_UNITS(WGAP), .LVL_W(LVL_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .enc_start(enc_start), .enc_sel(enc_sel),
        .enc_done(enc_done), .busy(busy), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [4:0] chr;
        logic       done;
        logic       rdy;
        int         lvl;
        logic       bsy;
        logic       st;
        int         sel;
        logic       er;
    } vec_t;

    vec_t vecs[18];
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   nstarts = 0;
    int   npush   = 0;

    function automatic vec_t mk(logic r, logic v, int c, logic d,
                                logic rdy, int lvl, logic b, logic s, int sel, logic e);
        vec_t x;
        x.rst = r; x.vld = v; x.chr = 5'(c); x.done = d;
        x.rdy = rdy; x.lvl = lvl; x.bsy = b; x.st = s; x.sel = sel; x.er = e;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock edge; outputs are then observed 1 time unit later.
    task automatic tick();
        if (in_valid && in_ready) npush++;
        @(posedge clk);
        #1;
        cyc++;
        if (enc_start) nstarts++;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        int n;
        int t;
        int bad;

        rst = 1'b1; in_valid = 1'b0; in_char = '0; enc_done = 1'b0;

        // Reset, then an invalid code followed by C, then a gap that ignores
        // a stray enc_done.
        //              rst v  chr d   rdy lvl b  st sel e
        vecs[0]  = mk(1, 0, 0,  0,  1,  0,  0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 30, 0,  1,  1,  1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 2,  0,  1,  1,  1, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0,  0,  1,  0,  1, 1, 2, 0);
        vecs[4]  = mk(0, 0, 0,  0,  1,  0,  1, 0, 2, 0);
        vecs[5]  = mk(0, 0, 0,  1,  1,  0,  1, 0, 2, 0);
        vecs[6]  = mk(0, 0, 0,  1,  1,  0,  1, 0, 2, 0);
        for (int i = 7; i <= 16; i++) vecs[i] = mk(0, 0, 0, 0, 1, 0, 1, 0, 2, 0);
        vecs[17] = mk(0, 0, 0,  0,  1,  0,  0, 0, 2, 0);

        #1;
        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].vld;
            in_char = vecs[i].chr; enc_done = vecs[i].done;
            tick();
            check($sformatf("v%0d in_ready", i),  int'(in_ready),  int'(vecs[i].rdy));
            check($sformatf("v%0d level", i),     int'(level),     vecs[i].lvl);
            check($sformatf("v%0d busy", i),      int'(busy),      int'(vecs[i].bsy));
            check($sformatf("v%0d enc_start", i), int'(enc_start), int'(vecs[i].st));
            check($sformatf("v%0d enc_sel", i),   int'(enc_sel),   vecs[i].sel);
            check($sformatf("v%0d err", i),       int'(err),       int'(vecs[i].er));
        end
        rst = 1'b0; in_valid = 1'b0; enc_done = 1'b0;

        // Single A: the latency from push to start, a single-cycle pulse, and
        // a gap of N cycles.
        nstarts = 0;
        in_valid = 1'b1; in_char = 5'd0;
        tick();
        in_valid = 1'b0;
        check("a_level_after_push", int'(level), 1);
        check("a_no_start_yet", int'(enc_start), 0);
        tick();
        check("a_start_k2", int'(enc_start), 1);
        check("a_sel", int'(enc_sel), 0);
        tick();
        check("a_start_single", int'(enc_start), 0);
        repeat (19) tick();
        enc_done = 1'b1; t = cyc;
        tick();
        enc_done = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check("a_gap_len", n, N);
        check("a_starts", nstarts, 1);

        // A word space at the head of the message, with nothing behind it:
        // level for one cycle plus the M-cycle gap.
        nstarts = 0;
        in_valid = 1'b1; in_char = 5'd26;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check("space_head_busy_len", n, 1 + M);
        check("space_head_starts", nstarts, 0);

        // A, space, B: the distance from done to the next start is N+M+3.
        nstarts = 0;
        in_valid = 1'b1; in_char = 5'd0;  tick();
        in_char = 5'd26; tick();
        in_char = 5'd1;  tick();
        in_valid = 1'b0;
        repeat (3) tick();
        enc_done = 1'b1; t = cyc;
        tick();
        enc_done = 1'b0;
        n = 0;
        while (!enc_start && n < 200) begin
            tick();
            n++;
        end
        check("aspb_done_to_start", cyc - t, N + M + 3);
        check("aspb_sel_b", int'(enc_sel), 1);
        repeat (2) tick();
        enc_done = 1'b1; tick(); enc_done = 1'b0;
        wait_idle("aspb_idle");
        check("aspb_starts", nstarts, 2);

        // Stalled encoder: DEPTH+1 characters are accepted, and the FIFO
        // stays full until the next pop.
        npush = 0;
        in_valid = 1'b1; in_char = 5'd3;
        repeat (15) tick();
        check("stall_pushes", npush, DEPTH + 1);
        check("stall_level", int'(level), DEPTH);
        check("stall_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        enc_done = 1'b1; t = cyc;
        tick();
        enc_done = 1'b0;
        n = 0; bad = 0;
        while (level == LVL_W'(DEPTH) && n < 50) begin
            if (in_ready) bad++;
            tick();
            n++;
        end
        check("stall_ready_held_low", bad, 0);
        check("stall_pop_cycle", cyc - t, N + 2);
        check("stall_level_after_pop", int'(level), 3);
        check("stall_in_ready_after_pop", int'(in_ready), 1);
        check("stall_restart", int'(enc_start), 1);

        // Reset while in WAIT with level=3; a late enc_done is ignored.
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(enc_start), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_sel", int'(enc_sel), 0);
        nstarts = 0;
        enc_done = 1'b1; tick(); enc_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bad++;
            tick();
        end
        check("rst_late_done_busy", bad, 0);
        check("rst_late_done_starts", nstarts, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
